// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: operand, MTHI/MTLO and start/busy/done bundle between control and the multiply/divide unit.
interface mult_div_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic             hiWrite;
    logic             loWrite;
    logic [WIDTH-1:0] writeData;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    modport master(output start, op, srcA, srcB, hiWrite, loWrite, writeData, input busy, done, hi, lo);
    modport slave(input start, op, srcA, srcB, hiWrite, loWrite, writeData, output busy, done, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU on operand magnitudes with HI/LO registers and MTHI/MTLO writes.
module mult_div_unit #(parameter int WIDTH = 32) (
    input logic            clk,
    input logic            rst_n,
    mult_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   m;
    logic [WIDTH-1:0]   src_a;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               div0;
    logic               sa;
    logic               sb;
    logic [WIDTH:0]     add;
    logic [WIDTH:0]     rem_try;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] step;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   r;
    // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide
    always_comb begin
        sa      = !bus.op[0] && bus.srcA[WIDTH-1];
        sb      = !bus.op[0] && bus.srcB[WIDTH-1];
        add     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
        rem_try = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff    = rem_try - {1'b0, m};
        step    = !is_div ? {add, acc[WIDTH-1:1]} :
                  diff[WIDTH] ? {rem_try[WIDTH-1:0], acc[WIDTH-2:0], 1'b0} :
                                {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        prod    = neg_q ? -acc : acc;
        q       = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        r       = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            m        <= '0;
            src_a    <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div0     <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.hi   <= '0;
            bus.lo   <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.hiWrite) bus.hi <= bus.writeData;
                    if (bus.loWrite) bus.lo <= bus.writeData;
                    if (bus.start) begin
                        state    <= CALC;
                        bus.busy <= 1'b1;
                        cnt      <= '0;
                        is_div   <= bus.op[1];
                        neg_q    <= sa ^ sb;
                        neg_r    <= sa;
                        div0     <= bus.op[1] && bus.srcB == '0;
                        src_a    <= bus.srcA;
                        m        <= sb ? -bus.srcB : bus.srcB;
                        acc      <= {{WIDTH{1'b0}}, sa ? -bus.srcA : bus.srcA};
                    end
                end
                CALC: begin
                    acc <= step;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                    // magnitude 0x80000000 / 1 negates back to 0x80000000, covering signed overflow without a special case
                    bus.hi   <= !is_div ? prod[2*WIDTH-1:WIDTH] : div0 ? src_a : r;
                    bus.lo   <= !is_div ? prod[WIDTH-1:0] : div0 ? '1 : q;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors against an arithmetic reference model compared every cycle, plus literal result checks.
module tb_mult_div_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit chk_on = 1'b0;
    int tests = 0;
    int fails = 0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic m_busy = 1'b0, m_done = 1'b0;
    int m_left = 0;

    mult_div_unit_if #(.WIDTH(32)) bus();
    mult_div_unit #(.WIDTH(32)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void ref_calc(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] h, output logic [31:0] l);
        longint sp;
        logic [63:0] up;
        h = '0;
        l = '0;
        case (o)
            2'd0: begin sp = longint'($signed(a)) * longint'($signed(b)); {h, l} = sp; end
            2'd1: begin up = {32'b0, a} * {32'b0, b}; {h, l} = up; end
            2'd2: begin
                if (b == 0) begin h = a; l = '1; end
                else if (a == 32'h8000_0000 && b == '1) begin h = '0; l = 32'h8000_0000; end
                else begin l = 32'($signed(a) / $signed(b)); h = 32'($signed(a) % $signed(b)); end
            end
            default: begin
                if (b == 0) begin h = a; l = '1; end
                else begin l = a / b; h = a % b; end
            end
        endcase
    endfunction

    // reference: result computed at acceptance, released after a fixed WIDTH+1 cycle delay
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (bus.hiWrite) m_hi = bus.writeData;
                if (bus.loWrite) m_lo = bus.writeData;
                if (bus.start) begin
                    ref_calc(bus.op, bus.srcA, bus.srcB, p_hi, p_lo);
                    m_busy = 1'b1;
                    m_left = 33;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_busy = 1'b0; m_done = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("busy", 32'(bus.busy), 32'(m_busy));
            chk("done", 32'(bus.done), 32'(m_done));
            chk("hi", bus.hi, m_hi);
            chk("lo", bus.lo, m_lo);
        end
    end

    task automatic go(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = o; bus.srcA = a; bus.srcB = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input bit inj);
        int cyc = 0;
        while (!bus.done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (inj) begin
                bus.start = (cyc == 5);
                if (cyc == 5) begin bus.op = 2'd1; bus.srcA = 32'd2; bus.srcB = 32'd2; end
                bus.hiWrite = (cyc == 10);
                bus.writeData = 32'hDEAD;
            end
        end
        chk("latency", cyc, 33);
    endtask

    initial begin
        bus.start = 1'b0; bus.op = '0; bus.srcA = '0; bus.srcB = '0;
        bus.hiWrite = 1'b0; bus.loWrite = 1'b0; bus.writeData = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_on = 1'b1;
        chk("rst_hi", bus.hi, 32'h0);
        chk("rst_lo", bus.lo, 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);

        go(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_busy", 32'(bus.busy), 32'h1);
        wait_done(1'b0);
        chk("multu_hi", bus.hi, 32'hFFFF_FFFE);
        chk("multu_lo", bus.lo, 32'h0000_0001);
        @(posedge clk); #1;
        chk("done_1cyc", 32'(bus.done), 32'h0);

        go(2'd0, 32'hFFFF_FFFD, 32'd7);
        wait_done(1'b0);
        chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
        chk("mult_lo", bus.lo, 32'hFFFF_FFEB);
        go(2'd2, 32'hFFFF_FFF9, 32'd2);
        wait_done(1'b0);
        chk("div_lo", bus.lo, 32'hFFFF_FFFD);
        chk("div_hi", bus.hi, 32'hFFFF_FFFF);

        go(2'd3, 32'd100, 32'd0);
        wait_done(1'b0);
        chk("div0_lo", bus.lo, 32'hFFFF_FFFF);
        chk("div0_hi", bus.hi, 32'h0000_0064);
        go(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(1'b0);
        chk("ovf_lo", bus.lo, 32'h8000_0000);
        chk("ovf_hi", bus.hi, 32'h0);

        go(2'd3, 32'd17, 32'd5);
        wait_done(1'b1);
        chk("ign_lo", bus.lo, 32'd3);
        chk("ign_hi", bus.hi, 32'd2);
        repeat (3) @(posedge clk);
        #1 chk("no_rebusy", 32'(bus.busy), 32'h0);

        @(posedge clk); #1;
        bus.loWrite = 1'b1; bus.writeData = 32'h1234_5678;
        @(posedge clk); #1;
        bus.loWrite = 1'b0;
        chk("mtlo_lo", bus.lo, 32'h1234_5678);
        chk("mtlo_hi", bus.hi, 32'd2);
        @(posedge clk); #1;
        bus.hiWrite = 1'b1; bus.loWrite = 1'b1; bus.writeData = 32'hCAFE_F00D;
        bus.start = 1'b1; bus.op = 2'd1; bus.srcA = 32'd3; bus.srcB = 32'd4;
        @(posedge clk); #1;
        bus.hiWrite = 1'b0; bus.loWrite = 1'b0; bus.start = 1'b0;
        chk("wr_start_hi", bus.hi, 32'hCAFE_F00D);
        chk("wr_start_lo", bus.lo, 32'hCAFE_F00D);
        chk("wr_start_busy", 32'(bus.busy), 32'h1);
        wait_done(1'b0);
        chk("wr_start_mhi", bus.hi, 32'h0);
        chk("wr_start_mlo", bus.lo, 32'd12);

        go(2'd1, 32'h0000_FFFF, 32'h0000_FFFF);
        repeat (11) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(bus.busy), 32'h0);
        chk("arst_done", 32'(bus.done), 32'h0);
        chk("arst_hi", bus.hi, 32'h0);
        chk("arst_lo", bus.lo, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bus.start = 1'b1; bus.op = 2'd3; bus.srcA = 32'd17; bus.srcB = 32'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("rel_busy", 32'(bus.busy), 32'h1);
        wait_done(1'b0);
        chk("rel_lo", bus.lo, 32'd3);
        chk("rel_hi", bus.hi, 32'd2);
        repeat (3) @(posedge clk);
        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
